// File: rtl/tts_pkg.sv
// Shared types and defaults for the lab truth-table sequencers.
// The state encoding is shared so later sequencers and their harnesses agree on it.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int SETTLE_DEFAULT = 20;

endpackage

// File: rtl/settle_counter.sv
// Settle-interval counter: counts while enabled, flags the last settle cycle.
// It stops at its terminal count, so SETTLE need not be a power of two.
module settle_counter
  import tts_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT,
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive-sweep controller: walks every input code, holds it for SETTLE
// cycles, then samples the unit outputs against EXP_TABLE and tallies errors.
module truth_table_sequencer
  import tts_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = SETTLE_DEFAULT,
  parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] f_in,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             sample_valid,
  output logic             mismatch,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic [N_IN-1:0]  first_fail_idx
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_q, err_d;
  logic [N_IN-1:0]   ffi_q, ffi_d;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic [N_OUT-1:0]  exp_f;
  logic              miss;

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  assign exp_f = EXP_TABLE[int'(vec_q) * N_OUT +: N_OUT];
  assign miss  = (state_q == SAMPLE) && (f_in != exp_f);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    // abort overrides everything, but the error tally stays for inspection
    if (abort) begin
      state_d = IDLE;
      vec_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = APPLY;
            vec_d   = '0;
            err_d   = '0;
            ffi_d   = '0;
            cnt_clr = 1'b1;
          end
        end
        APPLY: begin
          if (cnt_tc) state_d = SAMPLE;
          else        cnt_en  = 1'b1;
        end
        SAMPLE: begin
          if (miss) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) ffi_d = vec_q;
          end
          if (vec_q == '1) begin
            state_d = DONE;
          end else begin
            state_d = APPLY;
            vec_d   = vec_q + 1'b1;
            cnt_clr = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
    end
  end

  assign vec_out        = vec_q;
  assign busy           = (state_q == APPLY) || (state_q == SAMPLE);
  assign sample_valid   = (state_q == SAMPLE);
  assign mismatch       = miss;
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (err_q == '0);
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: the unit under test is modelled as f1=(a&b)|c, f2=a^d,
// with per-vector output corruption used to create mismatches.
module tb_truth_table_sequencer;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 2;
  localparam int SETTLE = 2;

  function automatic logic [1:0] model_f(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {(a & b) | c, a ^ d};
  endfunction

  function automatic logic [31:0] gen_table();
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i*2 +: 2] = model_f(4'(i));
    return t;
  endfunction

  localparam logic [31:0] EXP = gen_table();

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  f_in;
  logic [3:0]  vec_out;
  logic        busy, sample_valid, mismatch, done, pass;
  logic [4:0]  err_count;
  logic [3:0]  first_fail_idx;
  logic [15:0] fault_mask = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign f_in = model_f(vec_out) ^ {1'b0, fault_mask[vec_out]};

  truth_table_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(SETTLE), .EXP_TABLE(EXP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .vec_out(vec_out), .busy(busy), .sample_valid(sample_valid),
    .mismatch(mismatch), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  function automatic logic [17:0] all_outs();
    return {vec_out, busy, sample_valid, mismatch, done, pass, err_count, first_fail_idx};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if (all_outs() !== 18'h0) begin
      n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (all_outs() !== 18'h0) begin
        n_fail++; $display("FAIL idle_outs cyc %0d: got %h want 0", i, all_outs());
      end
    end
  endtask

  // Runs one full sweep; optionally pulses start right after vector inj_at samples.
  task automatic run_sweep(input string nm, input logic [15:0] mask, input int exp_err,
                           input int exp_ffi, input int inj_at);
    int cyc, k;
    bit fin;
    fault_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; k = 0; fin = 0;
    n_cmp++;
    if (vec_out !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s_first: vec %0d busy %b done %b want 0/1/0", nm, vec_out, busy, done);
    end
    while (!fin && cyc < 60) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (sample_valid) begin
        n_cmp++;
        if (cyc !== 3*k + 2 || vec_out !== 4'(k) || mismatch !== mask[k]) begin
          n_fail++;
          $display("FAIL %s_sample%0d: cyc %0d vec %0d mm %b want cyc %0d vec %0d mm %b",
                   nm, k, cyc, vec_out, mismatch, 3*k+2, k, mask[k]);
        end
        if (k == inj_at) start = 1'b1;
        k++;
      end else if (mismatch !== 1'b0) begin
        n_cmp++; n_fail++;
        $display("FAIL %s_mm_outside_sample: cyc %0d got 1 want 0", nm, cyc);
      end
      if (done) fin = 1;
    end
    n_cmp++;
    if (!fin || cyc !== 48 || k !== 16) begin
      n_fail++; $display("FAIL %s_done_cycle: got %0d (samples %0d) want 48 (16)", nm, cyc, k);
    end
    n_cmp++;
    if (err_count !== 5'(exp_err) || pass !== (exp_err == 0) || busy !== 1'b0 || vec_out !== 4'd15) begin
      n_fail++;
      $display("FAIL %s_result: err %0d pass %b busy %b vec %0d want %0d %b 0 15",
               nm, err_count, pass, busy, vec_out, exp_err, exp_err == 0);
    end
    if (exp_err != 0) begin
      n_cmp++;
      if (first_fail_idx !== 4'(exp_ffi)) begin
        n_fail++; $display("FAIL %s_first_fail: got %0d want %0d", nm, first_fail_idx, exp_ffi);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b1 || vec_out !== 4'd15) begin
      n_fail++; $display("FAIL %s_done_hold: done %b vec %0d want 1 15", nm, done, vec_out);
    end
  endtask

  task automatic wait_vec(input logic [3:0] target);
    int t;
    t = 0;
    while (vec_out !== target && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (vec_out !== target) begin
      n_cmp++; n_fail++;
      $display("FAIL wait_vec: got %0d want %0d", vec_out, target);
    end
  endtask

  task automatic test_abort();
    fault_mask = 16'h0008;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_vec(4'd7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== 4'd0 || sample_valid !== 1'b0 || pass !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: busy %b done %b vec %0d sv %b want 0 0 0 0", busy, done, vec_out, sample_valid);
    end
    n_cmp++;
    if (err_count !== 5'd1 || first_fail_idx !== 4'd3) begin
      n_fail++; $display("FAIL abort_retain: err %0d ffi %0d want 1 3", err_count, first_fail_idx);
    end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || vec_out !== 4'd0) begin
      n_fail++; $display("FAIL abort_beats_start: busy %b vec %0d want 0 0", busy, vec_out);
    end
    run_sweep("restart", 16'h0000, 0, 0, 4);
  endtask

  task automatic test_async_reset();
    fault_mask = 16'h0008;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_vec(4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== 18'h0) begin
      n_fail++; $display("FAIL async_reset_outs: got %h want 0", all_outs());
    end
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep("after_reset", 16'h0000, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    run_sweep("clean", 16'h0000, 0, 0, -1);
    run_sweep("single", 16'h0020, 1, 5, -1);
    run_sweep("multi", 16'h8208, 3, 3, -1);
    test_abort();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Exhaustive-sweep controller for the 4-input / 2-output combinational lab blocks. On `start` it walks the input vector {a,b,c,d} through every code from 0 to 2^N_IN-1. It holds each code for a settle interval, samples the block's outputs and compares them against an expected truth table. It reports an error count, the first failing index, and pass/done status. It replaces hand-written per-vector stimulus and sits between a top-level harness and the combinational unit under test.

Parameters:
N_IN, 4, number of unit inputs; vec_out[N_IN-1] drives a, vec_out[0] drives the last input (d).
N_OUT, 2, number of unit outputs; f_in[N_OUT-1] is f1.
SETTLE, 20, cycles each vector is held before sampling; must be ≥1.
EXP_TABLE, 0, (2^N_IN)*N_OUT-bit expected results; entry i occupies bits [i*N_OUT +: N_OUT].

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a sweep; honoured only in IDLE or DONE.
abort  input  1  level; returns to IDLE from any state.
f_in  input  N_OUT  outputs of the unit under test.
vec_out  output  N_IN  current input vector driven to the unit.
busy  output  1  high in APPLY or SAMPLE.
sample_valid  output  1  one-cycle pulse in each SAMPLE cycle.
mismatch  output  1  high with sample_valid when f_in ≠ expected.
done  output  1  high in DONE; held until the next start, abort or reset.
pass  output  1  high in DONE when err_count == 0; otherwise 0.
err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep; max 2^N_IN, no saturation needed.
first_fail_idx  output  N_IN  index of the first mismatch; meaningful only when err_count ≠ 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; vec_out, err_count, first_fail_idx and settle counter all 0; busy, sample_valid, mismatch, done and pass all 0.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE / DONE + start:
  - vec_out ← 0; err_count ← 0; first_fail_idx ← 0; done ← 0; pass ← 0; settle counter ← 0.
  - Next state APPLY. vec_out=0 is visible in the cycle after the start edge.
- APPLY: counter increments each cycle. When counter == SETTLE-1, go to SAMPLE. vec_out is stable throughout.
- SAMPLE (exactly 1 cycle):
  - sample_valid=1.
  - mismatch = (f_in ≠ EXP_TABLE[vec_out*N_OUT +: N_OUT]).
  - On mismatch: err_count+1, and if err_count was 0, first_fail_idx ← vec_out.
  - If vec_out == 2^N_IN-1, go to DONE. Otherwise vec_out+1, counter ← 0, go to APPLY.
- DONE: done=1; pass = (err_count==0); vec_out holds its last value; busy=0.
- Latency: each vector takes SETTLE+1 cycles. done rises in cycle 2^N_IN*(SETTLE+1) after the start edge; 336 cycles for the defaults.
- start while busy: ignored, with no restart.
- abort (any state, same cycle as start included): abort wins. Next state IDLE; busy, done, pass and sample_valid go to 0; vec_out ← 0; err_count and first_fail_idx are retained for inspection.
- Reset mid-sweep: immediate return to reset values, independent of clk.
- f_in is sampled only in SAMPLE; changes on f_in during APPLY have no effect.

Decomposition:
- Shared package `tts_pkg`: state enum (IDLE, APPLY, SAMPLE, DONE) and the default SETTLE constant.
- One sub-module, `settle_counter`: a $clog2(SETTLE)-bit counter with clear/enable inputs and a terminal-count output, reusable by later lab sequencers.
- FSM, vector register and compare logic live in the top module.

Test Plan:
- Reset then idle: with rst_n=0, then 1 and no start, all outputs stay 0 for 50 cycles.
- Clean sweep: SETTLE=2; bench model f1=(a&b)|c, f2=a^d; EXP_TABLE matches the model. A start pulse gives 16 sample_valid pulses, 3 cycles apart, with vec_out 0→15; done rises in cycle 48; pass=1; err_count=0.
- Single fault: same setup with EXP_TABLE entry 5 flipped. mismatch fires only at vec_out=5; done=1; pass=0; err_count=1; first_fail_idx=5.
- Multiple faults: entries 3, 9 and 15 corrupted. Result is err_count=3, first_fail_idx=3, pass=0.
- Abort / restart: assert abort at vec_out=7. Next cycle shows IDLE with busy=0, done=0 and vec_out=0. A start pulse mid-sweep is ignored. A fresh start after abort completes normally with err_count cleared.
- Async reset mid-sweep: pull rst_n low between clock edges at vec_out=10. Outputs clear immediately, before the next edge, and a subsequent start sweeps from 0.
